// File: rtl/window_gen_pkg.sv
// Shared types and helpers for the window_gen slice: FSM state encoding,
// window column indices and the window-count width helper.
package window_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Column slots inside each window row; COL_OLD sits in the MSBs of a row bus.
    localparam int COL_OLD = 2;
    localparam int COL_MID = 1;
    localparam int COL_NEW = 0;

    // Bits needed to count every window of an img_h x img_w frame, inclusive.
    function automatic int cnt_width(input int img_h, input int img_w);
        return $clog2((img_h - 2) * (img_w - 2) + 1);
    endfunction

endpackage

// File: rtl/window_gen_if.sv
// Pixel-in / window-out bus of window_gen. The window counter port exists
// only when WINDOW_GEN_WIN_CNT_EN is defined.
interface window_gen_if #(
    parameter int WIDTH = 8
`ifdef WINDOW_GEN_WIN_CNT_EN
  , parameter int CNT_W = window_gen_pkg::cnt_width(28, 28)
`endif
);
    import window_gen_pkg::*;

    logic [WIDTH-1:0]   in_data;
    logic               in_vld;
    logic               in_rdy;
    logic [3*WIDTH-1:0] activate2;
    logic [3*WIDTH-1:0] activate1;
    logic [3*WIDTH-1:0] activate0;
    logic               out_update;
    logic               out_frame_done;
`ifdef WINDOW_GEN_WIN_CNT_EN
    logic [CNT_W-1:0]   out_win_cnt;
`endif

    // Upstream feeder / downstream consumer view.
    modport master (
        output in_data, in_vld,
        input  in_rdy, activate2, activate1, activate0, out_update, out_frame_done
`ifdef WINDOW_GEN_WIN_CNT_EN
      , input  out_win_cnt
`endif
    );

    // The window generator itself.
    modport slave (
        input  in_data, in_vld,
        output in_rdy, activate2, activate1, activate0, out_update, out_frame_done
`ifdef WINDOW_GEN_WIN_CNT_EN
      , output out_win_cnt
`endif
    );

endinterface

// File: rtl/window_gen_line_buffer.sv
// Single-row delay line: dout is the pixel written DEPTH enabled shifts ago.
// Contents are deliberately not reset; the window logic never exposes them
// before they have been refilled with pixels of the current frame.
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Shift one pixel in per accepted handshake.
    always_ff @(posedge clk) begin
        if (en) mem <= {mem[DEPTH-2:0], din};
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_gen.sv
// 3x3 sliding-window generator for a raster pixel stream (stride 1, no pad).
// Two line buffers delay rows r-1 and r-2; a 3x3 shift window is updated on
// every handshake and copied to the activate* buses (latency 1) whenever it
// holds a complete window (row >= 2, col >= 2).
// Optional: WINDOW_GEN_WIN_CNT_EN adds out_win_cnt (windows in this frame).
module window_gen
    import window_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic         clk,
    input  logic         rst,
    window_gen_if.slave  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t                       state, state_nxt;
    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic                         hs, last_px, win_fire;
    logic                         in_rdy_c, frame_done_c;
    logic                         upd_q;
    logic [WIDTH-1:0]             lb1_out, lb0_out;
    logic [2:0][WIDTH-1:0]        tap;
    logic [2:0][2:0][WIDTH-1:0]   win, win_nxt, act;

    assign hs       = bus.in_vld & in_rdy_c;
    assign last_px  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    // Col >= 2 also keeps columns of the previous row out of the first windows.
    assign win_fire = hs && (row >= RW'(2)) && (col >= CW'(2));

    // Row r-1 and row r-2 delay lines, chained.
    line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .en   (hs),
        .din  (bus.in_data),
        .dout (lb1_out)
    );

    line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb0 (
        .clk  (clk),
        .en   (hs),
        .din  (lb1_out),
        .dout (lb0_out)
    );

    // Newest column entering each window row: bottom, middle, top.
    assign tap[0] = bus.in_data;
    assign tap[1] = lb1_out;
    assign tap[2] = lb0_out;

    for (genvar r = 0; r < 3; r++) begin : g_row
        assign win_nxt[r][COL_OLD] = win[r][COL_MID];
        assign win_nxt[r][COL_MID] = win[r][COL_NEW];
        assign win_nxt[r][COL_NEW] = tap[r];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: one frame per IDLE->ACTIVE->DONE pass.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACTIVE;
            ACTIVE:  if (hs && last_px) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: stall input for the single DONE cycle and while in reset.
    always_comb begin
        in_rdy_c     = !rst && (state != DONE);
        frame_done_c = (state == DONE);
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == DONE) begin
            col <= '0;
            row <= '0;
        end else if (hs) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // 3x3 shift window, moves one column left per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     win <= '0;
        else if (hs) win <= win_nxt;
    end

    // Presented window and its strobe; buses hold between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act   <= '0;
            upd_q <= 1'b0;
        end else begin
            upd_q <= win_fire;
            if (win_fire) act <= win_nxt;
        end
    end

    assign bus.in_rdy         = in_rdy_c;
    assign bus.out_frame_done = frame_done_c;
    assign bus.out_update     = upd_q;
    assign bus.activate2      = act[2];
    assign bus.activate1      = act[1];
    assign bus.activate0      = act[0];

`ifdef WINDOW_GEN_WIN_CNT_EN
    logic [cnt_width(IMG_H, IMG_W)-1:0] win_cnt;

    // Windows emitted this frame; counts with the strobe, cleared leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 win_cnt <= '0;
        else if (state == DONE)  win_cnt <= '0;
        else if (win_fire)       win_cnt <= win_cnt + 1'b1;
    end

    assign bus.out_win_cnt = win_cnt;
`endif

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen: a 4x4 instance and a 5x3 (row-wrap)
// instance. Drivers push the window expected from each handshake, computed
// directly from the frame array; a negedge monitor pops and compares.
module tb_window_gen;
    import window_gen_pkg::*;

    localparam int WIDTH = 8;
    localparam int W0 = 4, H0 = 4;
    localparam int W1 = 5, H1 = 3;

    typedef logic [WIDTH-1:0] px_t;
    typedef px_t frame_t[$];
    typedef struct packed { logic [3*WIDTH-1:0] a2, a1, a0; } win_t;
    typedef struct packed {
        logic rdy, vld, upd, done;
        win_t w;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1;
    int   checks = 0, failures = 0;
    win_t q0[$], q1[$];
    int   nwin[2], ndone[2];
    logic prev_hs[2];

    always #5 clk = ~clk;

    window_gen_if #(.WIDTH(WIDTH)
`ifdef WINDOW_GEN_WIN_CNT_EN
      , .CNT_W(cnt_width(H0, W0))
`endif
    ) b0 ();

    window_gen_if #(.WIDTH(WIDTH)
`ifdef WINDOW_GEN_WIN_CNT_EN
      , .CNT_W(cnt_width(H1, W1))
`endif
    ) b1 ();

    window_gen #(.WIDTH(WIDTH), .IMG_W(W0), .IMG_H(H0)) u0 (.clk(clk), .rst(rst0), .bus(b0));
    window_gen #(.WIDTH(WIDTH), .IMG_W(W1), .IMG_H(H1)) u1 (.clk(clk), .rst(rst1), .bus(b1));

    task automatic chk(input string nm, input int id, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h exp=%0h", nm, id, got, exp);
        end
    endtask

    function automatic obs_t obs(input int id);
        obs_t o;
        o.cnt = '0;
        if (id == 0) begin
            o.rdy = b0.in_rdy; o.vld = b0.in_vld; o.upd = b0.out_update; o.done = b0.out_frame_done;
            o.w = {b0.activate2, b0.activate1, b0.activate0};
`ifdef WINDOW_GEN_WIN_CNT_EN
            o.cnt = 16'(b0.out_win_cnt);
`endif
        end else begin
            o.rdy = b1.in_rdy; o.vld = b1.in_vld; o.upd = b1.out_update; o.done = b1.out_frame_done;
            o.w = {b1.activate2, b1.activate1, b1.activate0};
`ifdef WINDOW_GEN_WIN_CNT_EN
            o.cnt = 16'(b1.out_win_cnt);
`endif
        end
        return o;
    endfunction

    // Reference: the 3x3 neighbourhood ending at raster index i of frame f.
    function automatic win_t ref_win(input frame_t f, input int w, input int i);
        int r = i / w;
        int c = i % w;
        win_t x;
        x.a2 = {f[(r-2)*w + c-2], f[(r-2)*w + c-1], f[(r-2)*w + c]};
        x.a1 = {f[(r-1)*w + c-2], f[(r-1)*w + c-1], f[(r-1)*w + c]};
        x.a0 = {f[r*w + c-2],     f[r*w + c-1],     f[r*w + c]};
        return x;
    endfunction

    function automatic frame_t seq(input int n, input int base);
        frame_t f;
        for (int i = 0; i < n; i++) f.push_back(px_t'(base + i));
        return f;
    endfunction

    function automatic frame_t rnd(input int n);
        frame_t f;
        for (int i = 0; i < n; i++) f.push_back(px_t'($urandom_range(0, 255)));
        return f;
    endfunction

    task automatic set_in(input int id, input logic v, input px_t d);
        if (id == 0) begin b0.in_vld = v; b0.in_data = d; end
        else         begin b1.in_vld = v; b1.in_data = d; end
    endtask

    task automatic push(input int id, input win_t x);
        if (id == 0) q0.push_back(x);
        else         q1.push_back(x);
    endtask

    // gap_mode: 0 none, 1 idle cycle before every pixel, 2 random idles.
    // stop_at >= 0 abandons the frame after that many pixels.
    task automatic send_frame(input int id, input frame_t f, input int gap_mode, input int stop_at);
        int w = (id == 0) ? W0 : W1;
        for (int i = 0; i < f.size(); i++) begin
            logic ok;
            obs_t o;
            if (i == stop_at) break;
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                set_in(id, 1'b0, '0);
                @(posedge clk); #1;
            end
            set_in(id, 1'b1, f[i]);
            ok = 1'b0;
            for (int g = 0; g < 50 && !ok; g++) begin
                @(negedge clk);
                o  = obs(id);
                ok = o.rdy;
                if (ok && (i / w) >= 2 && (i % w) >= 2) push(id, ref_win(f, w, i));
                @(posedge clk); #1;
            end
            chk("handshake_timeout", id, ok, 1);
        end
        set_in(id, 1'b0, '0);
    endtask

    // Monitor: compare each strobed window, frame-done behaviour and reset state.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            obs_t o;
            logic rs, have;
            int   nexp;
            win_t e;
            o    = obs(id);
            rs   = (id == 0) ? rst0 : rst1;
            nexp = (id == 0) ? (H0-2)*(W0-2) : (H1-2)*(W1-2);
            if (rs) begin
                chk("reset_outputs", id, {o.rdy, o.upd, o.done, o.w}, '0);
`ifdef WINDOW_GEN_WIN_CNT_EN
                chk("win_cnt_reset", id, o.cnt, 0);
`endif
                nwin[id] = 0;
                prev_hs[id] = 1'b0;
                if (id == 0) q0.delete(); else q1.delete();
            end else begin
                if (o.upd) begin
                    chk("update_after_hs", id, prev_hs[id], 1);
                    have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    chk("window_expected", id, have, 1);
                    if (have) begin
                        e = (id == 0) ? q0.pop_front() : q1.pop_front();
                        chk("window", id, o.w, e);
                    end
                    nwin[id]++;
                end
`ifdef WINDOW_GEN_WIN_CNT_EN
                chk("win_cnt", id, o.cnt, nwin[id]);
`endif
                if (o.done) begin
                    chk("rdy_in_done", id, o.rdy, 0);
                    chk("windows_per_frame", id, nwin[id], nexp);
                    ndone[id]++;
                    nwin[id] = 0;
                end
                prev_hs[id] = o.vld & o.rdy;
            end
        end
    end

    initial begin
        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        fork
            begin
                send_frame(0, seq(16, 1), 0, -1);
                repeat (3) @(posedge clk);
                #1;
                send_frame(0, seq(16, 1), 1, -1);
                send_frame(0, seq(16, 1), 0, -1);
                send_frame(0, seq(16, 101), 0, -1);
                send_frame(0, seq(16, 1), 0, 10);
                rst0 = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst0 = 1'b0;
                send_frame(0, seq(16, 101), 0, -1);
                for (int k = 0; k < 6; k++) send_frame(0, rnd(16), 2, -1);
            end
            begin
                send_frame(1, seq(15, 1), 0, -1);
                for (int k = 0; k < 4; k++) send_frame(1, rnd(15), 2, -1);
            end
        join
        repeat (5) @(posedge clk);
        #1;
        chk("frames_done", 0, ndone[0], 11);
        chk("frames_done", 1, ndone[1], 5);
        chk("queue_drained", 0, q0.size(), 0);
        chk("queue_drained", 1, q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Upstream feeder for the 3x3 convolution core.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) for one IMG_H x IMG_W feature map.
- Buffers two full rows plus a 3x3 shift window, and presents each valid 3x3 window on three row buses with a one-cycle update strobe.
- Stride 1, no padding: (IMG_H-2)*(IMG_W-2) windows per frame.

Parameters:
- WIDTH, 8, pixel width in bits; must match the core's WIDTH.
- IMG_W, 28, pixels per row; must be >= 3.
- IMG_H, 28, rows per frame; must be >= 3.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  pixel value.
- in_vld  in  1  in_data is valid.
- in_rdy  out  1  block accepts a pixel; handshake occurs when in_vld & in_rdy.
- activate2  out  3*WIDTH  window top row (r-2).
- activate1  out  3*WIDTH  window middle row (r-1).
- activate0  out  3*WIDTH  window bottom row (r).
- out_update  out  1  one-cycle strobe: new window on activate2..0; drives the core's in_update.
- out_frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Bus layout per row: [3W-1:2W] = column c-2, [2W-1:W] = c-1, [W-1:0] = c (newest).
- Reset: all of the following are cleared.
  - Outputs: activate* = 0, out_update = 0, out_frame_done = 0, in_rdy = 0.
  - State = IDLE; row/col counters = 0; window registers = 0.
  - Line-buffer RAM contents are not cleared; stale data is never exposed.
- State IDLE:
  - in_rdy = 1.
  - First handshake stores pixel (0,0) and moves to ACTIVE.
- State ACTIVE:
  - in_rdy = 1.
  - Each handshake advances col; col wraps at IMG_W-1 to 0 and increments row.
  - The handshake on pixel (IMG_H-1, IMG_W-1) moves to DONE.
- State DONE:
  - Lasts exactly one cycle: in_rdy = 0, out_frame_done = 1.
  - Counters return to 0; next state is IDLE.
- Per handshake:
  - line buffer 1 shifts pixel (r-1,c) out to line buffer 0 and takes (r,c) in.
  - The window shift register shifts left by one column on all three rows.
- Window validity:
  - A handshake at row >= 2 and col >= 2 produces a window.
  - Registered activate* update and out_update = 1 in the following cycle (latency 1).
  - No update for col < 2 or row < 2; activate* hold their previous values.
- in_vld low: no state change, out_update = 0, activate* hold.
- No back-pressure from the core: each window is presented exactly once.
- Row wrap: window columns from the previous row never combine with the new row, because col < 2 suppresses the strobe until 3 fresh columns are present.
- Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as (0,0).
- Data is passed through unsigned; no arithmetic on pixel values.

Optional Feature:
- Macro: WINDOW_GEN_WIN_CNT_EN.
- When defined, adds output out_win_cnt, width $clog2((IMG_H-2)*(IMG_W-2)+1).
  - Increments with each out_update.
  - Holds its final value during DONE.
  - Clears on the transition into IDLE and on rst.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package window_gen_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE);
  - window column index constants (COL_OLD = 2, COL_MID = 1, COL_NEW = 0);
  - a helper function for the count width.
- One sub-module: line_buffer.
  - Single-row delay, depth IMG_W, width WIDTH.
  - Shifts only on an enable tied to the handshake.
  - Instantiated twice.

Test Plan:
- 4x4 frame, pixels 1..16, in_vld held high:
  - 4 out_update pulses.
  - First pulse is the cycle after pixel 11: activate2={1,2,3}, activate1={5,6,7}, activate0={9,10,11}.
  - Then windows ending at 12, 15, 16.
  - out_frame_done the cycle after pixel 16, with in_rdy = 0 that cycle.
- Same frame with in_vld low every other cycle: identical window sequence and values; out_update never asserts in a cycle that follows a cycle without a handshake.
- Two back-to-back 4x4 frames (1..16, then 101..116): second frame's first window is activate2={101,102,103}, activate1={105,106,107}, activate0={109,110,111}; no window mixes the two frames.
- rst asserted after pixel 10 of frame 1, then frame 101..116 is sent: outputs read 0 during reset; exactly 4 windows from the new frame, first as above.
- Row-wrap check, IMG_W=5, IMG_H=3, pixels 1..15: exactly 3 windows; bottom rows = {11,12,13}, {12,13,14}, {13,14,15}; no strobe on pixels 11 or 12.
- With WINDOW_GEN_WIN_CNT_EN, 28x28 random frame: out_win_cnt = 676 at out_frame_done and 0 in the following IDLE cycle.
